intr_controller: RTL

- Parametrised successor to the CPU's single-line interrupt path.
- Collects NUM_CH external interrupt sources and applies per-channel mask and edge/level mode.
- Raises one `intr` to the MCU and, on `int_ack`, latches a fixed-priority winner and presents its vector and ID.
- Sits on the I/O bus (`io_cs`/`io_wr`/`io_rd`) beside the I/O module; the next-generation CPU top instantiates it in place of the direct `intr` input.

---
 rtl/intr_controller.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/intr_controller.sv
// intr_controller: NUM_CH-channel interrupt controller with per-channel mask,
// edge/level mode, fixed priority (channel 0 highest) and an IDLE/REQ/SVC
// handshake with the MCU. Registers sit on the I/O bus beside the I/O module.
module intr_controller #(
    parameter int          NUM_CH   = 8,
    parameter int          ID_W     = 3,
    parameter logic [31:0] VEC_BASE = 32'h0000_0100
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] irq_in,
    input  logic              io_cs,
    input  logic              io_wr,
    input  logic              io_rd,
    input  logic [1:0]        addr,
    input  logic [31:0]       din,
    output logic [31:0]       dout,
    input  logic              int_ack,
    output logic              intr,
    output logic [31:0]       vec,
    output logic [ID_W-1:0]   active_id
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SVC  = 2'd2
    } state_t;

    localparam logic [1:0] A_MASK    = 2'd0;
    localparam logic [1:0] A_MODE    = 2'd1;
    localparam logic [1:0] A_PENDING = 2'd2;
    localparam logic [1:0] A_STATUS  = 2'd3;

    // Vector address of a channel: four bytes per entry above the base.
    function automatic logic [31:0] vec_of(input logic [ID_W-1:0] id);
        return VEC_BASE + (32'(id) << 2);
    endfunction

    state_t            state, state_nxt;
    logic [NUM_CH-1:0] sync_s1_p0, sync_s2_p1, sync_prev_p2;
    logic [NUM_CH-1:0] mask, mode, pending;
    logic [NUM_CH-1:0] rise, req, pend_clr, ack_clr;
    logic [ID_W-1:0]   winner;
    logic              wr_en, eoi, ack_take;
    logic [31:0]       unused_din_hi;

    assign wr_en    = io_cs & io_wr;
    assign eoi      = wr_en && (addr == A_STATUS);
    assign rise     = sync_s2_p1 & ~sync_prev_p2;
    assign req      = pending & mask;
    assign ack_take = (state == REQ) && int_ack && (|req);
    assign ack_clr  = ack_take ? (NUM_CH'(1) << winner) : '0;
    assign pend_clr = ((wr_en && (addr == A_PENDING)) ? din[NUM_CH-1:0] : '0) | ack_clr;
    // Upper write-data bits beyond the channel count carry no meaning.
    assign unused_din_hi = din >> NUM_CH;

    // Two-flop synchroniser plus a delayed copy for rising-edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_s1_p0   <= '0;
            sync_s2_p1   <= '0;
            sync_prev_p2 <= '0;
        end else begin
            // stage p0 -> p1 -> p2
            sync_s1_p0   <= irq_in;
            sync_s2_p1   <= sync_s1_p0;
            sync_prev_p2 <= sync_s2_p1;
        end
    end

    // Pending bits: edge channels latch rises (set beats clear), level channels mirror s2.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= (mode & (rise | (pending & ~pend_clr))) | (~mode & sync_s2_p1);
        end
    end

    // MASK and MODE configuration registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask <= '0;
            mode <= '0;
        end else if (wr_en) begin
            if (addr == A_MASK) mask <= din[NUM_CH-1:0];
            if (addr == A_MODE) mode <= din[NUM_CH-1:0];
        end
    end

    // Fixed priority: lowest-index requesting channel wins.
    always_comb begin
        winner = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req[i]) winner = ID_W'(i);
        end
    end

    // Capture the serviced channel at acknowledge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_id <= '0;
        end else if (ack_take) begin
            active_id <= winner;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // FSM next state and request output; no nesting while in service.
    always_comb begin
        state_nxt = state;
        intr      = 1'b0;
        case (state)
            IDLE: begin
                if (|req) state_nxt = REQ;
            end
            REQ: begin
                intr = 1'b1;
                if (!(|req))     state_nxt = IDLE;
                else if (int_ack) state_nxt = SVC;
            end
            SVC: begin
                if (eoi) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Vector follows the live winner until service, then the latched channel.
    always_comb begin
        vec = (state == SVC) ? vec_of(active_id) : vec_of(winner);
    end

    // Combinational register read port, zero when not selected for read.
    always_comb begin
        dout = '0;
        if (io_cs && io_rd) begin
            case (addr)
                A_MASK:    dout[NUM_CH-1:0] = mask;
                A_MODE:    dout[NUM_CH-1:0] = mode;
                A_PENDING: dout[NUM_CH-1:0] = pending;
                default: begin
                    dout[9:8]       = state;
                    dout[ID_W-1:0]  = active_id;
                end
            endcase
        end
    end

endmodule
